// File: rtl/boron_pkg.sv
// Shared definitions for the BORON key schedule: 4-bit S-box pair, step constants
// and the engine state encoding.
package boron_pkg;

  localparam int ROT_AMT = 13;
  localparam int RC_LSB  = 59;
  localparam int RC_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } ks_state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;
      4'h1: y = 4'h4;
      4'h2: y = 4'hB;
      4'h3: y = 4'h1;
      4'h4: y = 4'h7;
      4'h5: y = 4'h9;
      4'h6: y = 4'hC;
      4'h7: y = 4'hA;
      4'h8: y = 4'hD;
      4'h9: y = 4'h2;
      4'hA: y = 4'h0;
      4'hB: y = 4'hF;
      4'hC: y = 4'h8;
      4'hD: y = 4'h5;
      4'hE: y = 4'h3;
      4'hF: y = 4'h6;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hA;
      4'h1: y = 4'h3;
      4'h2: y = 4'h9;
      4'h3: y = 4'hE;
      4'h4: y = 4'h1;
      4'h5: y = 4'hD;
      4'h6: y = 4'hF;
      4'h7: y = 4'h4;
      4'h8: y = 4'hC;
      4'h9: y = 4'h5;
      4'hA: y = 4'h7;
      4'hB: y = 4'h2;
      4'hC: y = 4'h6;
      4'hD: y = 4'h8;
      4'hE: y = 4'h0;
      4'hF: y = 4'hB;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/boron_ks_step.sv
// One combinational key-schedule step: forward f (rotl, S-box, rc xor) or its exact
// inverse g, selected by inv.
module boron_ks_step
  import boron_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] key,
  input  logic [RC_W-1:0]  rc,
  input  logic             inv,
  output logic [KEY_W-1:0] next_key
);

  localparam logic WIDE_KEY = 1'(KEY_W == 128);

  logic [KEY_W-1:0] fwd_s;
  logic [KEY_W-1:0] inv_mix_s;
  logic [KEY_W-1:0] inv_s;

  // Both directions are built every cycle; inv only picks the result.
  always_comb begin
    fwd_s = {key[KEY_W-ROT_AMT-1:0], key[KEY_W-1:KEY_W-ROT_AMT]};
    fwd_s[3:0] = sbox4(fwd_s[3:0]);
    fwd_s[7:4] = WIDE_KEY ? sbox4(fwd_s[7:4]) : fwd_s[7:4];
    fwd_s[RC_LSB +: RC_W] = fwd_s[RC_LSB +: RC_W] ^ rc;

    inv_mix_s = key;
    inv_mix_s[RC_LSB +: RC_W] = inv_mix_s[RC_LSB +: RC_W] ^ rc;
    inv_mix_s[3:0] = sbox4_inv(inv_mix_s[3:0]);
    inv_mix_s[7:4] = WIDE_KEY ? sbox4_inv(inv_mix_s[7:4]) : inv_mix_s[7:4];
    inv_s = {inv_mix_s[ROT_AMT-1:0], inv_mix_s[KEY_W-1:ROT_AMT]};

    next_key = inv ? inv_s : fwd_s;
  end

endmodule

// File: rtl/boron_key_sched_engine.sv
// Iterative BORON key-schedule engine: streams ROUNDS+1 round keys over valid/ready,
// forward order directly or reverse order after a ROUNDS-cycle roll-forward.
module boron_key_sched_engine
  import boron_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 25,
  parameter int RK_W   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_rk_valid,
  input  logic             i_rk_ready,
  output logic [RK_W-1:0]  o_rk,
  output logic [4:0]       o_rk_idx,
  output logic             o_done
);

  localparam logic [4:0] LAST_IDX = 5'(ROUNDS);
  localparam logic [4:0] PREP_END = 5'(ROUNDS - 1);

  ks_state_e        state_r, state_next_s;
  logic [KEY_W-1:0] key_state_r, key_next_s, step_key_s;
  logic [4:0]       idx_r, idx_next_s, step_rc_s;
  logic             mode_r, mode_next_s;
  logic             busy_r, valid_r, done_r;
  logic             step_inv_s, hs_s, last_key_s;

  // Step control: PREP and forward EMIT roll with rc=idx+1, reverse EMIT unrolls with rc=idx.
  always_comb begin
    hs_s       = valid_r & i_rk_ready;
    step_inv_s = mode_r & (state_r == EMIT);
    step_rc_s  = step_inv_s ? idx_r : idx_r + 5'd1;
    last_key_s = mode_r ? (idx_r == 5'd0) : (idx_r == LAST_IDX);
  end

  boron_ks_step #(
    .KEY_W(KEY_W)
  ) u_step (
    .key     (key_state_r),
    .rc      (step_rc_s),
    .inv     (step_inv_s),
    .next_key(step_key_s)
  );

  // Next-state logic; idx doubles as the PREP round counter so EMIT starts at ROUNDS.
  always_comb begin
    state_next_s = state_r;
    key_next_s   = key_state_r;
    idx_next_s   = idx_r;
    mode_next_s  = mode_r;
    if (i_abort) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start) begin
            mode_next_s  = i_mode;
            key_next_s   = i_key;
            idx_next_s   = 5'd0;
            state_next_s = i_mode ? PREP : EMIT;
          end else begin
            state_next_s = IDLE;
          end
        end
        PREP: begin
          key_next_s = step_key_s;
          idx_next_s = idx_r + 5'd1;
          if (idx_r == PREP_END) begin
            state_next_s = EMIT;
          end else begin
            state_next_s = PREP;
          end
        end
        EMIT: begin
          if (hs_s && last_key_s) begin
            state_next_s = DONE;
          end else if (hs_s) begin
            key_next_s = step_key_s;
            idx_next_s = mode_r ? idx_r - 5'd1 : idx_r + 5'd1;
          end else begin
            state_next_s = EMIT;
          end
        end
        DONE:    state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State and output registers; flags are decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      key_state_r <= '0;
      idx_r       <= 5'd0;
      mode_r      <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      key_state_r <= key_next_s;
      idx_r       <= idx_next_s;
      mode_r      <= mode_next_s;
      busy_r      <= (state_next_s != IDLE);
      valid_r     <= (state_next_s == EMIT);
      done_r      <= (state_next_s == DONE);
    end
  end

  assign o_busy     = busy_r;
  assign o_rk_valid = valid_r;
  assign o_done     = done_r;
  assign o_rk       = key_state_r[RK_W-1:0];
  assign o_rk_idx   = idx_r;

endmodule

// File: tb/tb_boron_key_sched_engine.sv
// Directed bench: 80- and 128-bit engines run side by side on shared stimulus and are
// checked against an independent forward key-schedule model.
module tb_boron_key_sched_engine;

  localparam logic [127:0] MASK80 = {48'h0, {80{1'b1}}};

  logic         clk_s = 1'b0;
  logic         rst_s, start_s, mode_s, abort_s, ready_s;
  logic [127:0] key_s;
  logic         busy80_s, valid80_s, done80_s, busy128_s, valid128_s, done128_s;
  logic [63:0]  rk80_s, rk128_s;
  logic [4:0]   idx80_s, idx128_s;
  logic [63:0]  exp80 [0:25];
  logic [63:0]  exp128 [0:25];
  int           n_tests = 0;
  int           n_fail = 0;
  int           lat, e, cyc;

  always #5 clk_s = ~clk_s;

  boron_key_sched_engine #(.KEY_W(80), .ROUNDS(25), .RK_W(64)) dut80 (
    .clk(clk_s), .rst(rst_s), .i_start(start_s), .i_mode(mode_s), .i_key(key_s[79:0]),
    .i_abort(abort_s), .o_busy(busy80_s), .o_rk_valid(valid80_s), .i_rk_ready(ready_s),
    .o_rk(rk80_s), .o_rk_idx(idx80_s), .o_done(done80_s));

  boron_key_sched_engine #(.KEY_W(128), .ROUNDS(25), .RK_W(64)) dut128 (
    .clk(clk_s), .rst(rst_s), .i_start(start_s), .i_mode(mode_s), .i_key(key_s),
    .i_abort(abort_s), .o_busy(busy128_s), .o_rk_valid(valid128_s), .i_rk_ready(ready_s),
    .o_rk(rk128_s), .o_rk_idx(idx128_s), .o_done(done128_s));

  function automatic logic [3:0] tsb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hE4B179CA_D20F8536;
    return t[(15 - int'(x)) * 4 +: 4];
  endfunction

  function automatic logic [127:0] mf(input logic [127:0] k, input int w, input logic [4:0] rc);
    logic [127:0] m, r;
    m = (w == 80) ? MASK80 : {128{1'b1}};
    r = ((k << 13) | (k >> (w - 13))) & m;
    r[3:0] = tsb(r[3:0]);
    if (w == 128) r[7:4] = tsb(r[7:4]);
    r[63:59] = r[63:59] ^ rc;
    return r;
  endfunction

  task automatic build(input logic [127:0] k);
    logic [127:0] s8, s12;
    s8 = k & MASK80;
    s12 = k;
    for (int i = 0; i <= 25; i++) begin
      exp80[i] = s8[63:0];
      exp128[i] = s12[63:0];
      s8 = mf(s8, 80, 5'(i + 1));
      s12 = mf(s12, 128, 5'(i + 1));
    end
  endtask

  task automatic tick;
    @(posedge clk_s);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_key(input string tag, input int i);
    chk({tag, "_valid"}, 128'({valid80_s, valid128_s}), 128'(2'b11));
    chk({tag, "_idx"}, 128'({idx80_s, idx128_s}), 128'({5'(i), 5'(i)}));
    chk({tag, "_rk80"}, 128'(rk80_s), 128'(exp80[i]));
    chk({tag, "_rk128"}, 128'(rk128_s), 128'(exp128[i]));
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 128'({busy80_s, valid80_s, done80_s, busy128_s, valid128_s, done128_s}), 128'(6'b0));
  endtask

  task automatic chk_zero(input string tag);
    chk_idle({tag, "_flags"});
    chk({tag, "_idx"}, 128'({idx80_s, idx128_s}), 128'(10'd0));
    chk({tag, "_rk"}, {rk80_s, rk128_s}, 128'd0);
  endtask

  task automatic chk_done(input string tag);
    chk(tag, 128'({done80_s, done128_s, valid80_s, valid128_s}), 128'(4'b1100));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s = 1'b0; start_s = 1'b0; mode_s = 1'b0; abort_s = 1'b0; ready_s = 1'b0;
    key_s = 128'd0;
    tick; tick;
    chk_zero("reset");
    rst_s = 1'b1;
    tick;
    chk_idle("idle_after_rst");

    // Forward, all-zero key
    build(128'd0);
    ready_s = 1'b1; mode_s = 1'b0; start_s = 1'b1;
    tick;
    start_s = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      chk_key("fwd0", i);
      if (i == 1) begin
        chk("rk1_80", 128'(rk80_s), 128'(64'h0800_0000_0000_000E));
        chk("rk1_128", 128'(rk128_s), 128'(64'h0800_0000_0000_00EE));
      end
      tick;
    end
    chk_done("fwd0_done");
    tick;
    chk_idle("fwd0_end");

    // Reverse, random key
    key_s = {$urandom(), $urandom(), $urandom(), $urandom()};
    build(key_s);
    mode_s = 1'b1; start_s = 1'b1;
    tick;
    start_s = 1'b0;
    lat = 1;
    while (!valid80_s && lat < 100) begin
      tick;
      lat++;
    end
    chk("rev_latency", 128'(lat), 128'(26));
    for (int i = 25; i >= 0; i--) begin
      chk_key("rev", i);
      if (i == 0) chk("rev_last", {rk80_s, rk128_s}, {key_s[63:0], key_s[63:0]});
      tick;
    end
    chk_done("rev_done");
    tick;

    // Forward with random ready throttling and an ignored start while busy
    key_s = {$urandom(), $urandom(), $urandom(), $urandom()};
    build(key_s);
    mode_s = 1'b0; start_s = 1'b1;
    tick;
    start_s = 1'b0;
    e = 0; cyc = 0;
    while (e <= 25 && cyc < 1000) begin
      chk_key("thr", e);
      ready_s = 1'($urandom_range(0, 1));
      if (cyc == 4) begin
        start_s = 1'b1; mode_s = 1'b1; key_s = ~key_s;
      end else begin
        start_s = 1'b0;
      end
      if (ready_s) e++;
      tick;
      cyc++;
    end
    start_s = 1'b0; mode_s = 1'b0; ready_s = 1'b1;
    chk("thr_count", 128'(e), 128'(26));
    chk_done("thr_done");
    tick;

    // Abort at idx 7 together with a handshake
    key_s = {$urandom(), $urandom(), $urandom(), $urandom()};
    build(key_s);
    start_s = 1'b1;
    tick;
    start_s = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    chk_key("abort_at", 7);
    abort_s = 1'b1;
    tick;
    abort_s = 1'b0;
    chk_idle("abort_idle");
    tick;
    chk_idle("abort_no_done");
    start_s = 1'b1; abort_s = 1'b1;
    tick;
    start_s = 1'b0; abort_s = 1'b0;
    chk_idle("start_abort_idle");
    tick;
    chk_idle("start_abort_stay");
    start_s = 1'b1;
    tick;
    start_s = 1'b0;
    for (int i = 0; i <= 25; i++) begin
      chk_key("fresh", i);
      tick;
    end
    chk_done("fresh_done");
    tick;

    // Asynchronous reset during PREP
    key_s = {$urandom(), $urandom(), $urandom(), $urandom()};
    build(key_s);
    mode_s = 1'b1; start_s = 1'b1;
    tick;
    start_s = 1'b0;
    repeat (4) tick;
    chk("prep_busy", 128'({busy80_s, busy128_s, valid80_s}), 128'(3'b110));
    #2 rst_s = 1'b0;
    #1 chk_zero("rst_prep");
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle("post_rst_prep");
    end

    // Asynchronous reset during EMIT
    mode_s = 1'b0; start_s = 1'b1;
    tick;
    start_s = 1'b0;
    tick; tick;
    chk_key("emit_pre_rst", 2);
    #2 rst_s = 1'b0;
    #1 chk_zero("rst_emit");
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle("post_rst_emit");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
